xpmwrap_dpdistram_arb: RTL

XPMWRAP_DPDISTRAM_ARB -- requirements
Module: xpmwrap_dpdistram_arb

---
 rtl/xpmwrap_pkg.sv | 10 +
 rtl/xpmwrap_rr_arb2.sv | 17 +
 rtl/xpmwrap_dpdistram_arb.sv | 75 +++++++
 3 files changed

// File: rtl/xpmwrap_pkg.sv
// xpmwrap_pkg: shared constants and response tag type for the distributed-RAM port arbiter.
package xpmwrap_pkg;
  localparam int RD_LATENCY = 2;
  localparam int NUM_REQ = 2;
  localparam int CNT_W = 16;
  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;
endpackage

// File: rtl/xpmwrap_rr_arb2.sv
// xpmwrap_rr_arb2: two-way round-robin grant with a 1-bit pointer favouring the last loser.
module xpmwrap_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);
  logic r_ptr;
  always_comb begin
    o_grant = rst ? 2'b00 : (&i_valid) ? (r_ptr ? 2'b10 : 2'b01) : i_valid;
  end
  // o_grant[0] set means requester 0 won, so requester 1 is next in line
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= 1'b0;
    else if (|o_grant) r_ptr <= o_grant[0];
  end
endmodule

// File: rtl/xpmwrap_dpdistram_arb.sv
// xpmwrap_dpdistram_arb: shares port A of a latency-2 distributed RAM between two requesters.
// Define XPMWRAP_DPDISTRAM_ARB_STATS_EN to add saturating per-requester grant counters.
module xpmwrap_dpdistram_arb
  import xpmwrap_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp0_valid,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
`ifdef XPMWRAP_DPDISTRAM_ARB_STATS_EN
  output logic [CNT_W-1:0]      grant_cnt0,
  output logic [CNT_W-1:0]      grant_cnt1,
`endif
  output logic                  mem_ena,
  output logic                  mem_wea,
  output logic                  mem_regcea,
  output logic                  mem_rsta,
  output logic [ADDR_WIDTH-1:0] mem_addra,
  output logic [DATA_WIDTH-1:0] mem_dina,
  input  logic [DATA_WIDTH-1:0] mem_douta
);
  logic [1:0] w_grant;
  tag_t       r_tag [RD_LATENCY];
  xpmwrap_rr_arb2 u_arb (
    .clk    (clka),
    .rst    (rsta),
    .i_valid({req1_valid, req0_valid}),
    .o_grant(w_grant)
  );
  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign mem_ena    = |w_grant;
  assign mem_wea    = w_grant[0] ? req0_we : (w_grant[1] & req1_we);
  assign mem_addra  = w_grant[1] ? req1_addr : req0_addr;
  assign mem_dina   = w_grant[1] ? req1_wdata : req0_wdata;
  assign mem_regcea = 1'b1;
  assign mem_rsta   = rsta;
  assign rsp_rdata  = mem_douta;
  // tag pipe matches the RAM's two register stages so valid lines up with douta
  always_ff @(posedge clka) begin
    if (rsta) begin
      for (int i = 0; i < RD_LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= '{valid: mem_ena & ~mem_wea, id: w_grant[1]};
      for (int i = 1; i < RD_LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end
  assign rsp0_valid = ~rsta & r_tag[RD_LATENCY-1].valid & ~r_tag[RD_LATENCY-1].id;
  assign rsp1_valid = ~rsta & r_tag[RD_LATENCY-1].valid & r_tag[RD_LATENCY-1].id;
`ifdef XPMWRAP_DPDISTRAM_ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt [NUM_REQ];
  always_ff @(posedge clka) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rsta) r_cnt[i] <= '0;
      else if (w_grant[i] && r_cnt[i] != '1) r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  end
  assign grant_cnt0 = r_cnt[0];
  assign grant_cnt1 = r_cnt[1];
`endif
endmodule
